// File: rtl/uart_cmd_parser_if.sv
// Handshake bundle between the UART RX/TX pair and uart_cmd_parser.
// Carries the receiver strobe/byte, the transmitter DV/Done/Active handshake,
// and the LED / error outputs. "master" is the parser side, "slave" the environment.
interface uart_cmd_parser_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       i_Tx_Active;
  logic       i_Tx_Done;
  logic       o_Tx_DV;
  logic [7:0] o_Tx_Byte;
  logic [4:0] o_Led;
  logic       o_Cmd_Error;

  modport master (
    input  i_Rx_DV,
    input  i_Rx_Byte,
    input  i_Tx_Active,
    input  i_Tx_Done,
    output o_Tx_DV,
    output o_Tx_Byte,
    output o_Led,
    output o_Cmd_Error
  );

  modport slave (
    output i_Rx_DV,
    output i_Rx_Byte,
    output i_Tx_Active,
    output i_Tx_Done,
    input  o_Tx_DV,
    input  o_Tx_Byte,
    input  o_Led,
    input  o_Cmd_Error
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: collects ASCII bytes into a line buffer, decodes on CR,
// drives five LED enables and sends a two-byte acknowledge via the TX DV/Done handshake.
// Latency: LEDs/error and first TX request two edges after the CR edge; RX bytes are
// dropped while a reply is in progress. Optional macro UART_CMD_STATUS_EN enables the "S" query.
module uart_cmd_parser #(
  parameter int MAX_LEN      = 4,
  parameter int TIMEOUT_CLKS = 2949120
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  uart_cmd_parser_if.master bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_K  = 8'h4B;
  localparam logic [7:0] CH_E  = 8'h45;
  localparam logic [7:0] CH_L  = 8'h4C;
`ifdef UART_CMD_STATUS_EN
  localparam logic [7:0] CH_S  = 8'h53;
`endif

  typedef enum logic [2:0] {
    COLLECT,
    DROP,
    EXEC,
    TX_SEND,
    TX_WAIT
  } state_t;

  state_t           state;
  logic [7:0]       line_buf [MAX_LEN];
  logic [CNT_W-1:0] count;
  logic [TMO_W-1:0] tmo_cnt;
  logic             force_err;

  // Reply bookkeeping: the first byte varies, the second is always LF.
  logic [7:0]       reply_byte;
  logic             tx_sel;
  logic             done_seen;
  logic             apply_pending;
  logic             err_pending;
  logic [4:0]       led_pending;

  // Registered outputs
  logic [4:0]       led_q;
  logic             tx_dv_q;
  logic [7:0]       tx_byte_q;
  logic             cmd_err_q;

  // Decode results for the buffered line
  logic             led_ok;
  logic [2:0]       led_idx;
  logic [4:0]       led_next;
`ifdef UART_CMD_STATUS_EN
  logic             status_ok;
`endif

  assign bus.o_Led       = led_q;
  assign bus.o_Tx_DV     = tx_dv_q;
  assign bus.o_Tx_Byte   = tx_byte_q;
  assign bus.o_Cmd_Error = cmd_err_q;

  // Decode the buffered line: "Lnv" LED write and (optionally) "S" status query.
  always_comb begin
    led_ok   = 1'b0;
    led_idx  = line_buf[1][2:0] - 3'd1;
    led_next = led_q;
    if (count == CNT_W'(3) &&
        line_buf[0] == CH_L &&
        line_buf[1] >= 8'h31 && line_buf[1] <= 8'h35 &&
        (line_buf[2] == 8'h30 || line_buf[2] == 8'h31)) begin
      led_ok = 1'b1;
      led_next[led_idx] = line_buf[2][0];
    end
`ifdef UART_CMD_STATUS_EN
    status_ok = (count == CNT_W'(1)) && (line_buf[0] == CH_S);
`endif
  end

  // Main FSM: collect, drop overflowing lines, execute, and run the two-byte reply.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state         <= COLLECT;
      count         <= '0;
      tmo_cnt       <= '0;
      force_err     <= 1'b0;
      reply_byte    <= 8'h00;
      tx_sel        <= 1'b0;
      done_seen     <= 1'b0;
      apply_pending <= 1'b0;
      err_pending   <= 1'b0;
      led_pending   <= 5'b00000;
      led_q         <= 5'b00000;
      tx_dv_q       <= 1'b0;
      tx_byte_q     <= 8'h00;
      cmd_err_q     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) line_buf[i] <= 8'h00;
    end else begin
      tx_dv_q   <= 1'b0;
      cmd_err_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (bus.i_Rx_DV) begin
            // Any received byte restarts the idle window; a CR beats a same-edge timeout.
            tmo_cnt <= '0;
            if (bus.i_Rx_Byte == CH_CR) begin
              state <= EXEC;
            end else if (bus.i_Rx_Byte == CH_LF && count == '0) begin
              // Leading LF (e.g. from CR/LF line endings) is ignored.
            end else if (count == CNT_W'(MAX_LEN)) begin
              state <= DROP;
            end else begin
              for (int i = 0; i < MAX_LEN; i++) begin
                if (count == CNT_W'(i)) line_buf[i] <= bus.i_Rx_Byte;
              end
              count <= count + CNT_W'(1);
            end
          end else if (count != '0) begin
            if (tmo_cnt == TMO_W'(TIMEOUT_CLKS)) begin
              // Stale partial line: discard without reply or error.
              count   <= '0;
              tmo_cnt <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end else begin
            tmo_cnt <= '0;
          end
        end

        DROP: begin
          if (bus.i_Rx_DV && bus.i_Rx_Byte == CH_CR) begin
            force_err <= 1'b1;
            state     <= EXEC;
          end
        end

        EXEC: begin
          count         <= '0;
          force_err     <= 1'b0;
          tx_sel        <= 1'b0;
          apply_pending <= 1'b1;
          led_pending   <= led_q;
          err_pending   <= 1'b0;
          reply_byte    <= CH_E;
          state         <= TX_SEND;
          if (force_err) begin
            err_pending <= 1'b1;
          end else if (count == '0) begin
            apply_pending <= 1'b0;
            state         <= COLLECT;
          end else if (led_ok) begin
            led_pending <= led_next;
            reply_byte  <= CH_K;
          end
`ifdef UART_CMD_STATUS_EN
          else if (status_ok) begin
            reply_byte <= {3'b011, led_q};
          end
`endif
          else begin
            err_pending <= 1'b1;
          end
        end

        TX_SEND: begin
          // LED/error results land on the first TX_SEND edge, alongside the first request.
          if (apply_pending) begin
            led_q         <= led_pending;
            cmd_err_q     <= err_pending;
            apply_pending <= 1'b0;
          end
          if (!bus.i_Tx_Active) begin
            tx_dv_q   <= 1'b1;
            tx_byte_q <= tx_sel ? CH_LF : reply_byte;
            done_seen <= 1'b0;
            state     <= TX_WAIT;
          end
        end

        TX_WAIT: begin
          // Done may be held for two cycles; wait for it to clear along with Active.
          if (!done_seen) begin
            if (bus.i_Tx_Done) done_seen <= 1'b1;
          end else if (!bus.i_Tx_Done && !bus.i_Tx_Active) begin
            if (!tx_sel) begin
              tx_sel <= 1'b1;
              state  <= TX_SEND;
            end else begin
              state <= COLLECT;
            end
          end
        end

        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Testbench for uart_cmd_parser: directed lines from the test plan followed by
// randomized lines, checked against a line-level reference model. A simple
// transmitter model answers TX requests with Active/Done (Done held 1 or 2 cycles).
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int TMO  = 200;
  localparam int MAXL = 4;

  logic clk;
  logic rst;

  uart_cmd_parser_if ifc ();

  uart_cmd_parser #(
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (ifc)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] tx_log [$];
  int         err_pulses = 0;
  logic       prev_active = 1'b0;
  logic [4:0] exp_led = 5'b00000;
  logic [7:0] stim_b [$];
  int         stim_g [$];
  bit         inject_en = 1'b0;
  bit         rst_during_tx = 1'b0;

  logic [7:0] pool [12] = '{8'h4C, 8'h53, 8'h31, 8'h33, 8'h35, 8'h36,
                            8'h30, 8'h58, 8'h61, 8'h0A, 8'h6C, 8'h32};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: TX requests must not overlap a busy transmitter; count error pulses.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (ifc.o_Tx_DV) check("dv_while_active", 32'(prev_active), 32'd0);
      if (ifc.o_Cmd_Error) err_pulses++;
      prev_active = ifc.i_Tx_Active;
    end
  end

  // Transmitter model
  initial begin
    logic [7:0] held;
    ifc.i_Tx_Active = 1'b0;
    ifc.i_Tx_Done   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.o_Tx_DV) begin
        held = ifc.o_Tx_Byte;
        tx_log.push_back(held);
        ifc.i_Tx_Active = 1'b1;
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1;
        if (!rst_during_tx) check("tx_byte_stable", 32'(ifc.o_Tx_Byte), 32'(held));
        ifc.i_Tx_Active = 1'b0;
        ifc.i_Tx_Done   = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
        @(posedge clk);
        #1;
        ifc.i_Tx_Done = 1'b0;
      end
    end
  end

  task automatic load_str(input string s, input int g);
    stim_b = {};
    stim_g = {};
    for (int i = 0; i < s.len(); i++) begin
      stim_b.push_back(8'(s[i]));
      stim_g.push_back(g);
    end
    stim_b.push_back(8'h0D);
    stim_g.push_back(g);
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim_b.size(); i++) begin
      repeat (stim_g[i]) @(posedge clk);
      #1;
      ifc.i_Rx_DV   = 1'b1;
      ifc.i_Rx_Byte = stim_b[i];
      @(posedge clk);
      #1;
      ifc.i_Rx_DV = 1'b0;
    end
  endtask

  // Line-level reference: what text survives into the buffer, then what it means.
  task automatic model_eval(output int nb, output logic [7:0] r0, output logic e,
                            output logic [4:0] nl);
    logic [7:0] lb [$];
    bit drop;
    int idx;
    lb   = {};
    drop = 1'b0;
    for (int i = 0; i < stim_b.size(); i++) begin
      if (!drop && lb.size() > 0 && stim_g[i] > TMO) lb = {};
      if (stim_b[i] == 8'h0D) break;
      if (drop) continue;
      if (stim_b[i] == 8'h0A && lb.size() == 0) continue;
      if (lb.size() == MAXL) begin
        drop = 1'b1;
        continue;
      end
      lb.push_back(stim_b[i]);
    end
    nl = exp_led;
    e  = 1'b0;
    nb = 2;
    r0 = 8'h45;
    if (drop) begin
      e = 1'b1;
    end else if (lb.size() == 0) begin
      nb = 0;
    end else if (lb.size() == 3 && lb[0] == 8'h4C && lb[1] >= 8'h31 && lb[1] <= 8'h35 &&
                 (lb[2] == 8'h30 || lb[2] == 8'h31)) begin
      idx     = int'(lb[1]) - 49;
      nl[idx] = (lb[2] == 8'h31);
      r0      = 8'h4B;
    end
`ifdef UART_CMD_STATUS_EN
    else if (lb.size() == 1 && lb[0] == 8'h53) begin
      r0 = {3'b011, exp_led};
    end
`endif
    else begin
      e = 1'b1;
    end
  endtask

  task automatic run_line(input string tag);
    int nb;
    logic [7:0] r0;
    logic e;
    logic [4:0] nl;
    logic [4:0] old_led;
    int cyc;
    int ep0;
    model_eval(nb, r0, e, nl);
    old_led = exp_led;
    ep0     = err_pulses;
    send_stim();
    @(posedge clk);
    #1;
    check({tag, "/led_n1"}, 32'(ifc.o_Led), 32'(old_led));
    check({tag, "/err_n1"}, 32'(ifc.o_Cmd_Error), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "/led_n2"}, 32'(ifc.o_Led), 32'(nl));
    check({tag, "/err_n2"}, 32'(ifc.o_Cmd_Error), 32'(e));
    check({tag, "/txdv_n2"}, 32'(ifc.o_Tx_DV), 32'(nb > 0));
    exp_led = nl;
    cyc = 0;
    while ((tx_log.size() < nb || ifc.i_Tx_Active || ifc.i_Tx_Done) && cyc < 4000) begin
      @(posedge clk);
      #2;
      cyc++;
      if (inject_en && ifc.i_Tx_Active && $urandom_range(0, 3) == 0) begin
        ifc.i_Rx_DV   = 1'b1;
        ifc.i_Rx_Byte = 8'($urandom_range(0, 255));
        @(posedge clk);
        #2;
        ifc.i_Rx_DV = 1'b0;
        cyc++;
      end
    end
    repeat (8) @(posedge clk);
    #1;
    check({tag, "/wait_budget"}, 32'(cyc >= 4000), 32'd0);
    check({tag, "/tx_count"}, 32'(tx_log.size()), 32'(nb));
    if (nb == 2 && tx_log.size() == 2) begin
      check({tag, "/tx_b0"}, 32'(tx_log[0]), 32'(r0));
      check({tag, "/tx_b1"}, 32'(tx_log[1]), 32'h0A);
    end
    check({tag, "/err_pulses"}, 32'(err_pulses - ep0), 32'(e));
    check({tag, "/led_final"}, 32'(ifc.o_Led), 32'(exp_led));
    tx_log = {};
  endtask

  task automatic gen_random();
    int kind;
    int len;
    stim_b = {};
    stim_g = {};
    kind = $urandom_range(0, 3);
    if (kind == 0) begin
      stim_b.push_back(8'h4C);
      stim_b.push_back(8'(8'h31 + $urandom_range(0, 4)));
      stim_b.push_back(8'(8'h30 + $urandom_range(0, 1)));
    end else begin
      len = $urandom_range(0, 7);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) stim_b.push_back(8'($urandom_range(32, 126)));
        else stim_b.push_back(pool[$urandom_range(0, 11)]);
      end
    end
    for (int i = 0; i < stim_b.size(); i++) begin
      if ($urandom_range(0, 15) == 0) stim_g.push_back(TMO + $urandom_range(30, 80));
      else stim_g.push_back($urandom_range(1, 6));
    end
    stim_b.push_back(8'h0D);
    stim_g.push_back($urandom_range(1, 6));
  endtask

  initial begin
    int cyc;
    rst           = 1'b1;
    ifc.i_Rx_DV   = 1'b0;
    ifc.i_Rx_Byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_led", 32'(ifc.o_Led), 32'd0);
    check("reset_txdv", 32'(ifc.o_Tx_DV), 32'd0);
    check("reset_txbyte", 32'(ifc.o_Tx_Byte), 32'd0);
    check("reset_err", 32'(ifc.o_Cmd_Error), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    load_str("L31", 2);       run_line("l31");
    load_str("S", 3);         run_line("status");
    load_str("L61", 1);       run_line("l61");
    load_str("L3X", 2);       run_line("l3x");
    load_str("L1111111", 1);  run_line("overflow");
    load_str("L51", 2);       run_line("l51");
    load_str("", 2);          run_line("empty");
    stim_b = '{8'h0A, 8'h0D};
    stim_g = '{2, 2};
    run_line("lf_empty");

    // Timeout between "L2" and "1": only "1" remains.
    stim_b = '{8'h4C, 8'h32, 8'h31, 8'h0D};
    stim_g = '{2, 2, TMO + 40, 2};
    run_line("timeout");
    // Gap just below the limit keeps the line intact.
    stim_b = '{8'h4C, 8'h34, 8'h31, 8'h0D};
    stim_g = '{2, 2, TMO - 40, 2};
    run_line("no_timeout");

    // Reset between the two reply bytes abandons the LF.
    load_str("L21", 2);
    send_stim();
    cyc = 0;
    while (!(tx_log.size() >= 1 && ifc.i_Tx_Done) && cyc < 2000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("rst_wait_budget", 32'(cyc >= 2000), 32'd0);
    rst_during_tx = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_mid_txdv", 32'(ifc.o_Tx_DV), 32'd0);
    check("rst_mid_led", 32'(ifc.o_Led), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("rst_no_second_byte", 32'(tx_log.size()), 32'd1);
    check("rst_txdv_after", 32'(ifc.o_Tx_DV), 32'd0);
    tx_log        = {};
    exp_led       = 5'b00000;
    rst_during_tx = 1'b0;
    load_str("L51", 2);       run_line("after_reset");

    inject_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      gen_random();
      run_line("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
